// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register with write-back formatting.
//   - Aligns and sign/zero-extends load data (LW/LB/LBU/LH/LHU) before the
//     stage register, so every output is registered.
//   - Drives the register-file write port one cycle after MEM.
//   - Keeps a retired-instruction counter (instret).
//   - Optional HI/LO register pair, enabled by defining the macro HILO_EN.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   stall_mem, stall_wb   MEM stalled (insert bubble) / WB stalled (hold)
//   flush                 kill the instruction entering WB
//   mem_valid, mem_wreg   MEM instruction is real / writes a GPR
//   mem_waddr             destination GPR
//   mem_result            ALU result for non-load instructions
//   mem_is_load           instruction is a load
//   mem_ld_type           000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others LW
//   mem_addr_lo           load byte address [1:0]
//   mem_rdata             raw little-endian data-memory word
//   wb_we/wb_waddr/wb_wdata   register-file write port
//   wb_misalign           pulse: misaligned load reached WB
//   instret               retired-instruction count
//   (HILO_EN) mem_whilo, mem_hi, mem_lo in; hi_o, lo_o out
module mem_wb_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_mem,
  input  logic                  stall_wb,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_wreg,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [31:0]           mem_result,
  input  logic                  mem_is_load,
  input  logic [2:0]            mem_ld_type,
  input  logic [1:0]            mem_addr_lo,
  input  logic [31:0]           mem_rdata,
`ifdef HILO_EN
  input  logic                  mem_whilo,
  input  logic [31:0]           mem_hi,
  input  logic [31:0]           mem_lo,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
`endif
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [31:0]           wb_wdata,
  output logic                  wb_misalign,
  output logic [CNT_W-1:0]      instret
);

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  // ---------------------------------------------------------------------------
  // Load alignment and misalignment detection (combinational, ahead of the reg)
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        is_half;
  logic        is_word;
  logic        misalign;
  logic [31:0] wdata_next;
  logic        we_next;

  always_comb begin
    ld_byte = mem_rdata[{mem_addr_lo, 3'b000} +: 8];
    ld_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    ld_data = mem_rdata;
    case (mem_ld_type)
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_data = {24'h0, ld_byte};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;  // LW and the unused encodings
    endcase

    is_half = (mem_ld_type == LD_LH) || (mem_ld_type == LD_LHU);
    // Every encoding that is not a byte or half load behaves as LW.
    is_word = !is_half && (mem_ld_type != LD_LB) && (mem_ld_type != LD_LBU);

    misalign = mem_valid && mem_is_load &&
               ((is_half && mem_addr_lo[0]) || (is_word && (mem_addr_lo != 2'b00)));

    wdata_next = mem_is_load ? ld_data : mem_result;
    // r0 is hard-wired zero, so it is never written even though it retires.
    we_next    = mem_valid && mem_wreg && (mem_waddr != '0) && !misalign;
  end

  // ---------------------------------------------------------------------------
  // Stage register. Priority: rst > flush > stall_wb > stall_mem > normal.
  // ---------------------------------------------------------------------------
  logic                  valid_reg;
  logic                  we_reg;
  logic [REG_ADDR_W-1:0] waddr_reg;
  logic [31:0]           wdata_reg;
  logic                  misalign_reg;
  logic [CNT_W-1:0]      instret_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      misalign_reg <= 1'b0;
      instret_reg  <= '0;
    end else if (flush || (!stall_wb && stall_mem)) begin
      // Bubble. A stalled MEM instruction stays put and is captured later,
      // so it must not be counted here.
      valid_reg    <= 1'b0;
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      misalign_reg <= 1'b0;
    end else if (!stall_wb) begin
      valid_reg    <= mem_valid;
      we_reg       <= we_next;
      waddr_reg    <= mem_waddr;
      wdata_reg    <= wdata_next;
      misalign_reg <= misalign;
      if (mem_valid && !misalign) begin
        instret_reg <= instret_reg + CNT_W'(1);  // wraps naturally at 2^CNT_W
      end
    end
    // stall_wb alone: hold everything
  end

  assign wb_we       = we_reg;
  assign wb_waddr    = waddr_reg;
  assign wb_wdata    = wdata_reg;
  assign wb_misalign = misalign_reg;
  assign instret     = instret_reg;

`ifdef HILO_EN
  // ---------------------------------------------------------------------------
  // HI/LO: staged alongside the GPR result, committed on the following edge.
  // ---------------------------------------------------------------------------
  logic        whilo_reg;
  logic [31:0] hi_stg_reg;
  logic [31:0] lo_stg_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      whilo_reg  <= 1'b0;
      hi_stg_reg <= '0;
      lo_stg_reg <= '0;
    end else if (flush || (!stall_wb && stall_mem)) begin
      whilo_reg  <= 1'b0;
      hi_stg_reg <= '0;
      lo_stg_reg <= '0;
    end else if (!stall_wb) begin
      whilo_reg  <= mem_valid && mem_whilo;
      hi_stg_reg <= mem_hi;
      lo_stg_reg <= mem_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (whilo_reg && !stall_wb) begin
      hi_reg <= hi_stg_reg;
      lo_reg <= lo_stg_reg;
    end
  end

  // Bypass so a consumer sees the new HI/LO in the WB cycle itself.
  assign hi_o = whilo_reg ? hi_stg_reg : hi_reg;
  assign lo_o = whilo_reg ? lo_stg_reg : lo_reg;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed vectors with literal expectations plus
// a behavioural model checked every cycle. A second instance with a 3-bit
// counter exercises the instret wrap-around.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_mem, stall_wb, flush;
  logic        mem_valid, mem_wreg, mem_is_load;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result, mem_rdata;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;

  logic        wb_we, wb_misalign;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, instret;

  logic        s_we, s_misalign;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [2:0]  s_instret;

`ifdef HILO_EN
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo, hi_o, lo_o, s_hi_o, s_lo_o;
`endif

  mem_wb_stage #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_waddr(mem_waddr),
    .mem_result(mem_result), .mem_is_load(mem_is_load), .mem_ld_type(mem_ld_type),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
`ifdef HILO_EN
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .hi_o(hi_o), .lo_o(lo_o),
`endif
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_misalign(wb_misalign), .instret(instret)
  );

  mem_wb_stage #(.REG_ADDR_W(5), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_waddr(mem_waddr),
    .mem_result(mem_result), .mem_is_load(mem_is_load), .mem_ld_type(mem_ld_type),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
`ifdef HILO_EN
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .hi_o(s_hi_o), .lo_o(s_lo_o),
`endif
    .wb_we(s_we), .wb_waddr(s_waddr), .wb_wdata(s_wdata),
    .wb_misalign(s_misalign), .instret(s_instret)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model_load(input logic [2:0] ty, input logic [1:0] lo,
                                             input logic [31:0] rd);
    int unsigned lo_i = lo;
    int unsigned b = (rd >> (8 * lo_i)) & 32'hFF;
    int unsigned h = (rd >> (16 * (lo_i / 2))) & 32'hFFFF;
    case (ty)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic int unsigned access_size(input logic [2:0] ty);
    if (ty == 3'd1 || ty == 3'd2) return 1;
    if (ty == 3'd3 || ty == 3'd4) return 2;
    return 4;
  endfunction

  logic        e_we, e_mis;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  int unsigned e_cnt;

  always @(posedge clk) begin
    logic mis;
    int unsigned lo_i;
    lo_i = mem_addr_lo;
    if (rst) begin
      e_we = 0; e_mis = 0; e_waddr = 0; e_wdata = 0; e_cnt = 0;
    end else if (flush || (!stall_wb && stall_mem)) begin
      e_we = 0; e_mis = 0; e_waddr = 0; e_wdata = 0;
    end else if (!stall_wb) begin
      mis     = mem_valid && mem_is_load && ((lo_i % access_size(mem_ld_type)) != 0);
      e_we    = mem_valid && mem_wreg && (mem_waddr != 0) && !mis;
      e_mis   = mis;
      e_waddr = mem_waddr;
      e_wdata = mem_is_load ? model_load(mem_ld_type, mem_addr_lo, mem_rdata) : mem_result;
      if (mem_valid && !mis) e_cnt = e_cnt + 1;
    end
    #1;
    check("m_we", {31'b0, wb_we}, {31'b0, e_we});
    check("m_waddr", {27'b0, wb_waddr}, {27'b0, e_waddr});
    check("m_misalign", {31'b0, wb_misalign}, {31'b0, e_mis});
    if (!e_mis) check("m_wdata", wb_wdata, e_wdata);
    check("m_instret", instret, e_cnt);
    check("m_instret_small", {29'b0, s_instret}, e_cnt & 32'h7);
    check("m_small_we", {31'b0, s_we}, {31'b0, e_we});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic op(input logic wreg, input logic [4:0] wa, input logic [31:0] res,
                    input logic ld, input logic [2:0] ty, input logic [1:0] lo,
                    input logic [31:0] rd);
    @(negedge clk);
    mem_valid = 1; mem_wreg = wreg; mem_waddr = wa; mem_result = res;
    mem_is_load = ld; mem_ld_type = ty; mem_addr_lo = lo; mem_rdata = rd;
    @(posedge clk); #2;
  endtask

  task automatic idle();
    @(negedge clk);
    mem_valid = 0; stall_mem = 0; stall_wb = 0; flush = 0; rst = 0;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  typedef struct {
    logic [2:0]  ty;
    logic [1:0]  lo;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  // rdata = 0x80FF_0102: byte0=02 byte1=01 byte2=FF byte3=80
  vec_t vecs[12] = '{
    '{3'd1, 2'd0, 32'h0000_0002, 1'b0},
    '{3'd1, 2'd2, 32'hFFFF_FFFF, 1'b0},
    '{3'd2, 2'd2, 32'h0000_00FF, 1'b0},
    '{3'd2, 2'd1, 32'h0000_0001, 1'b0},
    '{3'd3, 2'd0, 32'h0000_0102, 1'b0},
    '{3'd4, 2'd2, 32'h0000_80FF, 1'b0},
    '{3'd3, 2'd2, 32'hFFFF_80FF, 1'b0},
    '{3'd0, 2'd0, 32'h80FF_0102, 1'b0},
    '{3'd7, 2'd0, 32'h80FF_0102, 1'b0},
    '{3'd4, 2'd1, 32'h0000_0000, 1'b1},
    '{3'd0, 2'd3, 32'h0000_0000, 1'b1},
    '{3'd5, 2'd2, 32'h0000_0000, 1'b1}
  };

  initial begin
    rst = 1; stall_wb = 1; stall_mem = 0; flush = 0;
    mem_valid = 0; mem_wreg = 0; mem_waddr = 0; mem_result = 0;
    mem_is_load = 0; mem_ld_type = 0; mem_addr_lo = 0; mem_rdata = 0;
`ifdef HILO_EN
    mem_whilo = 0; mem_hi = 0; mem_lo = 0;
`endif
    // Reset held while stall_wb=1
    repeat (3) tick();
    check("rst_we", {31'b0, wb_we}, 32'd0);
    check("rst_instret", instret, 32'd0);
    idle(); tick(); tick();
    check("idle_wdata", wb_wdata, 32'd0);
    check("idle_misalign", {31'b0, wb_misalign}, 32'd0);

    // ALU write r5
    op(1, 5, 32'h1234_5678, 0, 0, 0, 0);
    check("alu_we", {31'b0, wb_we}, 32'd1);
    check("alu_waddr", {27'b0, wb_waddr}, 32'd5);
    check("alu_wdata", wb_wdata, 32'h1234_5678);
    check("alu_instret", instret, 32'd1);

    op(1, 6, 0, 1, 3'd1, 2'd3, 32'h80FF_0102);
    check("lb_wdata", wb_wdata, 32'hFFFF_FF80);
    op(1, 6, 0, 1, 3'd2, 2'd3, 32'h80FF_0102);
    check("lbu_wdata", wb_wdata, 32'h0000_0080);
    op(1, 6, 0, 1, 3'd3, 2'd2, 32'h8001_7FFF);
    check("lh_wdata", wb_wdata, 32'hFFFF_8001);
    check("lh_instret", instret, 32'd4);

    // Misaligned LH: no write, one-cycle pulse, no retire
    op(1, 6, 0, 1, 3'd3, 2'd1, 32'h8001_7FFF);
    check("mis_we", {31'b0, wb_we}, 32'd0);
    check("mis_pulse", {31'b0, wb_misalign}, 32'd1);
    check("mis_instret", instret, 32'd4);

    // Write to r0 retires but does not write; also ends the misalign pulse
    op(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    check("r0_we", {31'b0, wb_we}, 32'd0);
    check("r0_waddr", {27'b0, wb_waddr}, 32'd0);
    check("r0_mis_cleared", {31'b0, wb_misalign}, 32'd0);
    check("r0_instret", instret, 32'd5);

    // stall_wb for 3 cycles freezes outputs
    op(1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0);
    @(negedge clk);
    stall_wb = 1; mem_waddr = 8; mem_result = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_waddr", {27'b0, wb_waddr}, 32'd7);
      check("stall_wdata", wb_wdata, 32'hDEAD_BEEF);
      check("stall_instret", instret, 32'd6);
    end
    @(negedge clk); stall_wb = 0;
    tick();
    check("unstall_waddr", {27'b0, wb_waddr}, 32'd8);
    check("unstall_instret", instret, 32'd7);

    // stall_mem: bubble, then the same instruction retires once
    stall_mem = 1;
    op(1, 10, 32'h55, 0, 0, 0, 0);
    check("smem_we", {31'b0, wb_we}, 32'd0);
    check("smem_instret", instret, 32'd7);
    stall_mem = 0;
    op(1, 10, 32'h55, 0, 0, 0, 0);
    check("smem_release_we", {31'b0, wb_we}, 32'd1);
    check("smem_release_instret", instret, 32'd8);

    // flush beats stall_wb
    flush = 1; stall_wb = 1;
    op(1, 9, 32'h99, 0, 0, 0, 0);
    check("flush_we", {31'b0, wb_we}, 32'd0);
    check("flush_wdata", wb_wdata, 32'd0);
    check("flush_instret", instret, 32'd8);
    flush = 0; stall_wb = 0;

    // Load alignment table
    foreach (vecs[i]) begin
      op(1, 5'(i + 1), 0, 1, vecs[i].ty, vecs[i].lo, 32'h80FF_0102);
      check("tbl_we", {31'b0, wb_we}, {31'b0, !vecs[i].mis});
      check("tbl_misalign", {31'b0, wb_misalign}, {31'b0, vecs[i].mis});
      if (!vecs[i].mis) check("tbl_wdata", wb_wdata, vecs[i].exp);
    end

    // Misalign pulse held during stall_wb
    op(1, 3, 0, 1, 3'd0, 2'd1, 32'h1);
    @(negedge clk); stall_wb = 1;
    tick(); tick();
    check("mis_hold", {31'b0, wb_misalign}, 32'd1);
    idle(); tick();
    check("mis_release", {31'b0, wb_misalign}, 32'd0);

    // Reset during stall wins
    @(negedge clk); rst = 1; stall_wb = 1; mem_valid = 1;
    tick();
    check("rst_stall_instret", instret, 32'd0);
    check("rst_stall_waddr", {27'b0, wb_waddr}, 32'd0);
    idle();

    // Counter wrap on the 3-bit instance: 7 -> 0 on the 8th retirement
    for (int i = 0; i < 8; i++) op(1, 1, 32'(i), 0, 0, 0, 0);
    check("wrap_small", {29'b0, s_instret}, 32'd0);
    check("wrap_big", instret, 32'd8);

`ifdef HILO_EN
    mem_whilo = 1; mem_hi = 32'hA; mem_lo = 32'hB;
    op(0, 0, 0, 0, 0, 0, 0);
    check("hi_bypass", hi_o, 32'hA);
    check("lo_bypass", lo_o, 32'hB);
    mem_whilo = 0; mem_hi = 0; mem_lo = 0;
    idle(); tick(); tick();
    check("hi_after", hi_o, 32'hA);
    check("lo_after", lo_o, 32'hB);
`endif

    idle(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
